// File: rtl/fsm_seq_decoder_if.sv
// Instruction and memory-side bus of the sequenced decoder.
// Handshake rules:
//   instruction: a transfer happens on a rising edge where instr_valid=1 and
//   instr_ready=1. The source holds opcode/op1/op2 stable while instr_valid=1.
//   instr_ready is high only while the decoder is idle.
//   memory: mem_req/mem_we/addresses stay stable until mem_ack=1 is seen in
//   the wait state or the wait times out. mem_we is meaningful only while
//   mem_req=1.
interface fsm_seq_decoder_if #(
  parameter int ADDR_W = 2,
  parameter int CNT_W  = 8
);
  logic              instr_valid;
  logic              instr_ready;
  logic [2:0]        opcode;
  logic [ADDR_W-1:0] op1;
  logic [ADDR_W-1:0] op2;
  logic [2:0]        alu_opcode;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [ADDR_W-1:0] wrt_addr;
  logic              wrt_en;
  logic              load_data;
  logic              mem_req;
  logic              mem_we;
  logic              mem_ack;
  logic              busy;
  logic              err;
  logic [CNT_W-1:0]  instr_cnt;

  // Instruction source / memory model side.
  modport master (
    output instr_valid, opcode, op1, op2, mem_ack,
    input  instr_ready, alu_opcode, rd_addr1, rd_addr2, wrt_addr, wrt_en,
           load_data, mem_req, mem_we, busy, err, instr_cnt
  );

  // Decoder side.
  modport slave (
    input  instr_valid, opcode, op1, op2, mem_ack,
    output instr_ready, alu_opcode, rd_addr1, rd_addr2, wrt_addr, wrt_en,
           load_data, mem_req, mem_we, busy, err, instr_cnt
  );
endinterface

// File: rtl/fsm_seq_decoder.sv
// Sequenced instruction decoder for the Fibonacci datapath.
// One instruction at a time: IDLE accepts, EXEC drives the register file and
// ALU for one cycle, LOAD/STORE additionally wait in MEM_WAIT for mem_ack or
// a timeout. Retired instructions are counted with saturation.
module fsm_seq_decoder #(
  parameter int ADDR_W  = 2,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  fsm_seq_decoder_if.slave    bus,
  output logic [1:0]          o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_EXEC     = 2'd1,
    S_MEM_WAIT = 2'd2
  } state_t;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_SET   = 3'b001;
  localparam logic [2:0] OP_INC   = 3'b010;
  localparam logic [2:0] OP_DEC   = 3'b011;
  localparam logic [2:0] OP_LOAD  = 3'b100;
  localparam logic [2:0] OP_STORE = 3'b101;
  localparam logic [2:0] OP_ADD   = 3'b110;
  localparam logic [2:0] OP_COPY  = 3'b111;

  localparam int              TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            r_state;
  state_t            w_next_state;
  logic [2:0]        r_opcode;
  logic [ADDR_W-1:0] r_op1;
  logic [ADDR_W-1:0] r_op2;
  logic [TO_W-1:0]   r_to_cnt;
  logic [CNT_W-1:0]  r_instr_cnt;

  // Decoded fields of the latched instruction (valid in EXEC and MEM_WAIT).
  logic [ADDR_W-1:0] w_dec_rd1;
  logic [ADDR_W-1:0] w_dec_rd2;
  logic [ADDR_W-1:0] w_dec_wa;
  logic              w_dec_wr;
  logic              w_dec_mem;
  logic              w_dec_store;

  // FSM-driven outputs and control.
  logic              w_ready;
  logic              w_busy;
  logic [2:0]        w_alu;
  logic [ADDR_W-1:0] w_rd1;
  logic [ADDR_W-1:0] w_rd2;
  logic [ADDR_W-1:0] w_wa;
  logic              w_wrt_en;
  logic              w_load_data;
  logic              w_mem_req;
  logic              w_mem_we;
  logic              w_err;
  logic              w_retire;
  logic              w_to_inc;
  logic              w_accept;

  assign w_accept = (r_state == S_IDLE) && bus.instr_valid;

  // Field decode of the latched opcode into register-file/memory intent.
  always_comb begin
    w_dec_rd1   = '0;
    w_dec_rd2   = '0;
    w_dec_wa    = '0;
    w_dec_wr    = 1'b0;
    w_dec_mem   = 1'b0;
    w_dec_store = 1'b0;
    case (r_opcode)
      OP_SET: begin
        w_dec_wa = r_op1;
        w_dec_wr = 1'b1;
      end
      OP_INC, OP_DEC: begin
        w_dec_rd1 = r_op1;
        w_dec_wa  = r_op1;
        w_dec_wr  = 1'b1;
      end
      OP_ADD: begin
        w_dec_rd1 = r_op1;
        w_dec_rd2 = r_op2;
        w_dec_wa  = r_op1;
        w_dec_wr  = 1'b1;
      end
      OP_COPY: begin
        w_dec_rd1 = r_op2;
        w_dec_wa  = r_op1;
        w_dec_wr  = 1'b1;
      end
      OP_LOAD: begin
        w_dec_wa  = r_op1;
        w_dec_mem = 1'b1;
      end
      OP_STORE: begin
        w_dec_rd1   = r_op1;
        w_dec_mem   = 1'b1;
        w_dec_store = 1'b1;
      end
      default: ;  // NOP drives nothing
    endcase
  end

  // Next-state and output logic. Write/error strobes are masked by rst so a
  // reset landing on a completing cycle never commits anything.
  always_comb begin
    w_next_state = r_state;
    w_ready      = 1'b0;
    w_busy       = 1'b0;
    w_alu        = 3'b000;
    w_rd1        = '0;
    w_rd2        = '0;
    w_wa         = '0;
    w_wrt_en     = 1'b0;
    w_load_data  = 1'b0;
    w_mem_req    = 1'b0;
    w_mem_we     = 1'b0;
    w_err        = 1'b0;
    w_retire     = 1'b0;
    w_to_inc     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (bus.instr_valid) w_next_state = S_EXEC;
      end
      S_EXEC: begin
        w_busy    = 1'b1;
        w_alu     = r_opcode;
        w_rd1     = w_dec_rd1;
        w_rd2     = w_dec_rd2;
        w_wa      = w_dec_wa;
        w_wrt_en  = w_dec_wr && !rst;
        w_mem_req = w_dec_mem;
        w_mem_we  = w_dec_store;
        if (w_dec_mem) begin
          w_next_state = S_MEM_WAIT;
        end else begin
          w_next_state = S_IDLE;
          w_retire     = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        w_busy    = 1'b1;
        w_alu     = r_opcode;
        w_rd1     = w_dec_rd1;
        w_rd2     = w_dec_rd2;
        w_wa      = w_dec_wa;
        w_mem_req = 1'b1;
        w_mem_we  = w_dec_store;
        if (bus.mem_ack) begin
          w_next_state = S_IDLE;
          w_retire     = 1'b1;
          if (!w_dec_store) begin
            // The load write-back cycle drops mem_req so a write strobe and a
            // memory request never coincide.
            w_mem_req   = 1'b0;
            w_wrt_en    = !rst;
            w_load_data = !rst;
          end
        end else if (r_to_cnt == TO_LAST) begin
          w_next_state = S_IDLE;
          w_err        = !rst;
        end else begin
          w_to_inc = 1'b1;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register, instruction latch, timeout counter and retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_opcode    <= '0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_to_cnt    <= '0;
      r_instr_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_opcode <= bus.opcode;
        r_op1    <= bus.op1;
        r_op2    <= bus.op2;
      end
      if (w_to_inc) r_to_cnt <= r_to_cnt + 1'b1;
      else          r_to_cnt <= '0;
      if (w_retire && (r_instr_cnt != CNT_MAX)) r_instr_cnt <= r_instr_cnt + 1'b1;
    end
  end

  assign bus.instr_ready = w_ready;
  assign bus.busy        = w_busy;
  assign bus.alu_opcode  = w_alu;
  assign bus.rd_addr1    = w_rd1;
  assign bus.rd_addr2    = w_rd2;
  assign bus.wrt_addr    = w_wa;
  assign bus.wrt_en      = w_wrt_en;
  assign bus.load_data   = w_load_data;
  assign bus.mem_req     = w_mem_req;
  assign bus.mem_we      = w_mem_we;
  assign bus.err         = w_err;
  assign bus.instr_cnt   = r_instr_cnt;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_fsm_seq_decoder.sv
// Bench for fsm_seq_decoder: directed instruction sequences, a cycle-level
// expectation model built from the instruction table, and literal pins.
module tb_fsm_seq_decoder;
  localparam int ADDR_W  = 2;
  localparam int CNT_W   = 2;
  localparam int TIMEOUT = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int VW      = 18;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fsm_seq_decoder_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();
  logic [1:0] dbg_state;

  fsm_seq_decoder #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [VW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int m_cnt = 0;      // model of the retired-instruction counter
  int t_mreq = 0;     // observed mem_req cycles
  int t_err = 0;      // observed err cycles
  int t_wen = 0;      // observed wrt_en cycles
  int t_busy = 0;     // observed busy cycles
  int n_wait = 0;     // MEM_WAIT cycles spent by the last memory op
  logic [VW-1:0] snap_exec;
  logic [VW-1:0] snap_ack;

  // Vector layout: rdy,busy,alu[3],rd1[2],rd2[2],wa[2],wen,ld,mreq,mwe,err,cnt[2]
  function automatic logic [VW-1:0] obs();
    return {bus.instr_ready, bus.busy, bus.alu_opcode, bus.rd_addr1, bus.rd_addr2,
            bus.wrt_addr, bus.wrt_en, bus.load_data, bus.mem_req, bus.mem_we,
            bus.err, bus.instr_cnt};
  endfunction

  function automatic int sat(input int x);
    return (x > CNT_MAX) ? CNT_MAX : x;
  endfunction

  // ph: 0 = waiting for an instruction, 1 = execute cycle, 2 = memory wait.
  function automatic logic [VW-1:0] model(input int ph, input logic [2:0] op,
                                          input logic [1:0] a, input logic [1:0] b,
                                          input logic ack, input logic to,
                                          input logic r, input int cnt);
    logic rdy, bsy, we, ld, mr, mw, er;
    logic [2:0] alu;
    logic [1:0] r1, r2, wa, c;
    rdy = 0; bsy = 0; alu = 0; r1 = 0; r2 = 0; wa = 0;
    we = 0; ld = 0; mr = 0; mw = 0; er = 0;
    c = 2'(cnt);
    if (ph == 0) begin
      rdy = 1;
    end else begin
      bsy = 1;
      alu = op;
      case (op)
        3'd1: begin wa = a; we = 1; end
        3'd2, 3'd3: begin r1 = a; wa = a; we = 1; end
        3'd6: begin r1 = a; r2 = b; wa = a; we = 1; end
        3'd7: begin r1 = b; wa = a; we = 1; end
        3'd4: begin wa = a; mr = 1; end
        3'd5: begin r1 = a; mr = 1; mw = 1; end
        default: ;
      endcase
      if (ph == 2) begin
        if (ack && op == 3'd4) begin mr = 0; mw = 0; we = 1; ld = 1; end
        if (to && !ack) er = 1;
      end
      if (r) begin we = 0; ld = 0; er = 0; end
    end
    return {rdy, bsy, alu, r1, r2, wa, we, ld, mr, mw, er, c};
  endfunction

  // ---------------- compare process ----------------
  initial begin
    logic [VW-1:0] e, o;
    forever begin
      @(negedge clk);
      if (bus.mem_req) t_mreq++;
      if (bus.err)     t_err++;
      if (bus.wrt_en)  t_wen++;
      if (bus.busy)    t_busy++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        o = obs();
        n_cmp++;
        if (o !== e) begin
          n_bad++;
          $display("FAIL outputs t=%0t got=%h exp=%h", $time, o, e);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic [VW-1:0] e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.instr_valid = 0;
    bus.mem_ack = 0;
    repeat (n) step(model(0, 3'd0, 2'd0, 2'd0, 0, 0, 0, m_cnt));
  endtask

  // ack_at: MEM_WAIT cycle (1-based) carrying mem_ack, 0 = never.
  // rst_at: MEM_WAIT cycle carrying rst, -1 = rst during EXEC, 0 = none.
  task automatic issue(input logic [2:0] op, input logic [1:0] a, input logic [1:0] b,
                       input int ack_at, input bit hold, input bit ack_in_exec,
                       input int rst_at);
    bit ak, to, rr;
    bus.instr_valid = 1;
    bus.opcode = op;
    bus.op1 = a;
    bus.op2 = b;
    bus.mem_ack = 0;
    step(model(0, op, a, b, 0, 0, 0, m_cnt));
    if (!hold) bus.instr_valid = 0;
    bus.mem_ack = ack_in_exec;
    rst = (rst_at == -1);
    #1 snap_exec = obs();
    step(model(1, op, a, b, 0, 0, rst_at == -1, m_cnt));
    bus.instr_valid = 0;
    bus.mem_ack = 0;
    if (rst_at == -1) begin
      rst = 0;
      m_cnt = 0;
      return;
    end
    if (op != 3'd4 && op != 3'd5) begin
      m_cnt = sat(m_cnt + 1);
      return;
    end
    n_wait = 0;
    for (int k = 1; k <= TIMEOUT; k++) begin
      ak = (k == ack_at);
      to = (!ak && k == TIMEOUT);
      rr = (k == rst_at);
      bus.mem_ack = ak;
      rst = rr;
      #1 if (ak) snap_ack = obs();
      step(model(2, op, a, b, ak, to, rr, m_cnt));
      n_wait++;
      bus.mem_ack = 0;
      if (rr) begin rst = 0; m_cnt = 0; break; end
      if (ak) begin m_cnt = sat(m_cnt + 1); break; end
      if (to) break;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1;
    bus.instr_valid = 0;
    bus.opcode = 0;
    bus.op1 = 0;
    bus.op2 = 0;
    bus.mem_ack = 0;
    @(posedge clk);
    #1;
    idle(2);
    rst = 0;
    #1;
    check("reset_ready", int'(bus.instr_ready), 1);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_cnt", int'(bus.instr_cnt), 0);
    check("reset_strobes", int'(bus.wrt_en | bus.mem_req | bus.err | bus.load_data), 0);
    idle(1);

    // ADD r1,r2
    issue(3'd6, 2'd1, 2'd2, 0, 0, 0, 0);
    check("add_rd1", int'(snap_exec[12:11]), 1);
    check("add_rd2", int'(snap_exec[10:9]), 2);
    check("add_wa", int'(snap_exec[8:7]), 1);
    check("add_wen", int'(snap_exec[6]), 1);
    check("add_alu", int'(snap_exec[15:13]), 6);
    #1;
    check("add_ready", int'(bus.instr_ready), 1);
    check("add_cnt", int'(bus.instr_cnt), 1);
    idle(1);

    // LOAD r3, ack after 3 empty waits
    t_mreq = 0;
    issue(3'd4, 2'd3, 2'd0, 4, 0, 0, 0);
    check("load_mreq_cycles", t_mreq, 4);
    check("load_ack_wen", int'(snap_ack[6]), 1);
    check("load_ack_ld", int'(snap_ack[5]), 1);
    check("load_ack_wa", int'(snap_ack[8:7]), 3);
    #1;
    check("load_cnt", int'(bus.instr_cnt), 2);
    idle(1);

    // STORE r2, no ack (ack during EXEC must be ignored)
    t_err = 0;
    t_wen = 0;
    issue(3'd5, 2'd2, 2'd1, 0, 0, 1, 0);
    check("store_waits", n_wait, 16);
    check("store_err", t_err, 1);
    check("store_wen", t_wen, 0);
    #1;
    check("store_cnt", int'(bus.instr_cnt), 2);
    idle(1);

    // Remaining opcodes, back to back, counter saturates at 3
    issue(3'd1, 2'd3, 2'd0, 0, 0, 0, 0);
    issue(3'd2, 2'd2, 2'd1, 0, 0, 0, 0);
    issue(3'd3, 2'd0, 2'd3, 0, 0, 0, 0);
    issue(3'd7, 2'd1, 2'd3, 0, 1, 0, 0);
    issue(3'd5, 2'd3, 2'd0, 1, 0, 0, 0);
    idle(1);

    // Reset in MEM_WAIT of a LOAD, with ack in the same cycle
    t_wen = 0;
    issue(3'd4, 2'd1, 2'd0, 2, 0, 0, 2);
    check("rst_wait_wen", t_wen, 0);
    #1;
    check("rst_wait_cnt", int'(bus.instr_cnt), 0);
    check("rst_wait_ready", int'(bus.instr_ready), 1);
    idle(1);

    // Reset during EXEC of an ADD
    issue(3'd6, 2'd0, 2'd1, 0, 0, 0, -1);
    check("rst_exec_wen", t_wen, 0);
    idle(1);

    // Five NOPs, first with valid held through EXEC
    t_busy = 0;
    issue(3'd0, 2'd0, 2'd0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) issue(3'd0, 2'(i), 2'(3 - i), 0, 0, 0, 0);
    idle(2);
    check("nop_busy_cycles", t_busy, 5);
    check("nop_cnt_sat", int'(bus.instr_cnt), 3);
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
